// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS pipeline registers: reset PC, stage bundle layouts,
// and the elastic-stage state encoding.
package mips_pipe_pkg;

  localparam logic [31:0] PC_RESET = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_st_e;

  // IF/ID: {pc, instr, ctrl}
  localparam int IF_ID_W       = 65;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_INSTR_LSB = 1;
  localparam int IF_ID_PC_LSB  = 33;

  // ID/EX: {pc, rs_val, rt_val, imm, rs_idx, rt_idx, rd, ctrl}
  localparam int ID_EX_W        = 155;
  localparam int ID_EX_CTRL_W   = 12;
  localparam int ID_EX_RD_LSB   = 12;
  localparam int ID_EX_RT_LSB   = 17;
  localparam int ID_EX_RS_LSB   = 22;
  localparam int ID_EX_IMM_LSB  = 27;
  localparam int ID_EX_RTV_LSB  = 59;
  localparam int ID_EX_RSV_LSB  = 91;
  localparam int ID_EX_PC_LSB   = 123;

  // EX/MEM: {pc, alu, wdata, rd, ctrl}
  localparam int EX_MEM_W      = 106;
  localparam int EX_MEM_CTRL_W = 5;
  localparam int EX_MEM_PC_LSB = 74;

  // MEM/WB: {alu, mem, rd, ctrl}
  localparam int MEM_WB_W      = 71;
  localparam int MEM_WB_CTRL_W = 2;

  function automatic logic [ID_EX_W-1:0] id_ex_reset_val();
    return {PC_RESET, {(ID_EX_W-32){1'b0}}};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter, falling-edge clocked; holds at all-ones once reached.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_d = (inc_i && !sat_o) ? cnt_q + CNT_W'(1) : cnt_q;
  assign cnt_o = cnt_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with 2-entry skid (or 1 entry), flush and bubble control-zeroing.
// Latency 1 edge; in_ready is registered with skid enabled, so a stall never loses or repeats data.
module pipe_stage_elastic
  import mips_pipe_pkg::*;
#(
  parameter int                DATA_W    = 155,
  parameter int                CTRL_W    = 12,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_st_e          state_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              rdy_q, alive_q;
  logic              in_fire, out_fire, stall_inc, stall_sat;

  assign out_valid = (state_q != ST_EMPTY);
  // Without skid, a full stage can still accept on the edge its head leaves.
  assign in_ready  = SKID_EN ? rdy_q : (alive_q && ((state_q == ST_EMPTY) || out_ready));
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign occupancy = (state_q == ST_TWO) ? 2'd2 : ((state_q == ST_ONE) ? 2'd1 : 2'd0);
  assign out_data  = {main_q[DATA_W-1:CTRL_W], out_valid ? main_q[CTRL_W-1:0] : {CTRL_W{1'b0}}};

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      rdy_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (flush) begin
        state_q <= ST_EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
        rdy_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            rdy_q <= 1'b1;
            if (in_fire) begin
              main_q  <= in_data;
              state_q <= ST_ONE;
            end
          end
          ST_ONE: begin
            rdy_q <= 1'b1;
            if (in_fire && out_fire) begin
              main_q <= in_data;
            end else if (in_fire && SKID_EN) begin
              skid_q  <= in_data;
              state_q <= ST_TWO;
              rdy_q   <= 1'b0;
            end else if (out_fire) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              main_q  <= skid_q;
              state_q <= ST_ONE;
              rdy_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign stall_inc = out_valid && !out_ready && !flush && !stall_sat;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt),
    .sat_o (stall_sat)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_elastic;
  import mips_pipe_pkg::*;

  localparam int DW = 155;
  localparam int CW = 12;
  localparam logic [DW-1:0] RST_EXP = {32'h0040_0000, {(DW-32){1'b0}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // skid DUT and its CNT_W=4 twin share one input set
  logic          flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, in_ready_s, out_valid_s;
  logic [DW-1:0] out_data, out_data_s;
  logic [1:0]    occupancy, occupancy_s;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt_s;

  logic          ns_flush = 1'b0, ns_in_valid = 1'b0, ns_out_ready = 1'b0;
  logic [DW-1:0] ns_in_data = '0;
  logic          ns_in_ready, ns_out_valid;
  logic [DW-1:0] ns_out_data;
  logic [1:0]    ns_occupancy;
  logic [15:0]   ns_stall_cnt;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .RESET_VAL(id_ex_reset_val()), .SKID_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .RESET_VAL(id_ex_reset_val()), .SKID_EN(1'b1), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .occupancy(occupancy_s), .stall_cnt(stall_cnt_s));

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .RESET_VAL(id_ex_reset_val()), .SKID_EN(1'b0), .CNT_W(16)) dut_ns (
    .clk(clk), .reset(reset), .flush(ns_flush), .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data), .occupancy(ns_occupancy), .stall_cnt(ns_stall_cnt));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a bounded FIFO per DUT, updated on every active edge.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] nq[$];
  logic [DW-1:0] m_last = RST_EXP, n_last = RST_EXP;
  int  c16 = 0, c4 = 0, nc16 = 0;
  bit  m_alive = 0, n_alive = 0;
  bit  m_inf, m_outf, n_inf, n_outf;

  function automatic logic m_rdy();
    return m_alive && (mq.size() < 2);
  endfunction
  function automatic logic n_rdy();
    return n_alive && ((nq.size() == 0) || ns_out_ready);
  endfunction
  function automatic logic [DW-1:0] m_data();
    return (mq.size() != 0) ? mq[0] : {m_last[DW-1:CW], {CW{1'b0}}};
  endfunction
  function automatic logic [DW-1:0] n_data();
    return (nq.size() != 0) ? nq[0] : {n_last[DW-1:CW], {CW{1'b0}}};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      mq.delete(); nq.delete();
      m_last = RST_EXP; n_last = RST_EXP;
      c16 = 0; c4 = 0; nc16 = 0;
      m_alive = 0; n_alive = 0;
    end else begin
      m_inf  = in_valid && m_rdy();
      m_outf = (mq.size() != 0) && out_ready;
      if (flush) begin
        mq.delete(); m_last = RST_EXP;
      end else begin
        if (mq.size() != 0 && !out_ready) begin
          if (c16 < 65535) c16++;
          if (c4 < 15) c4++;
        end
        if (m_outf) void'(mq.pop_front());
        if (m_inf) mq.push_back(in_data);
        if (mq.size() != 0) m_last = mq[0];
      end
      m_alive = 1;

      n_inf  = ns_in_valid && n_rdy();
      n_outf = (nq.size() != 0) && ns_out_ready;
      if (ns_flush) begin
        nq.delete(); n_last = RST_EXP;
      end else begin
        if (nq.size() != 0 && !ns_out_ready && nc16 < 65535) nc16++;
        if (n_outf) void'(nq.pop_front());
        if (n_inf) nq.push_back(ns_in_data);
        if (nq.size() != 0) n_last = nq[0];
      end
      n_alive = 1;
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  // Drive one cycle of stimulus; returns at the sampling point after the next active edge.
  task automatic tick(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(posedge clk); #1;
  endtask

  logic ns_rdy_seen, ns_rdy_want;
  task automatic ns_tick(input logic iv, input logic [DW-1:0] id, input logic ordy);
    ns_in_valid = iv; ns_in_data = id; ns_out_ready = ordy;
    #1;
    ns_rdy_seen = ns_in_ready;
    ns_rdy_want = n_rdy();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_data !== RST_EXP) begin n_bad++; $display("FAIL reset_data: got %h want %h", out_data, RST_EXP); end
    n_cmp++; if (out_data[DW-1:DW-32] !== 32'h0040_0000) begin n_bad++; $display("FAIL reset_pc: got %h want 00400000", out_data[DW-1:DW-32]); end
    n_cmp++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin n_bad++; $display("FAIL reset_stall: got %0d/%0d want 0", stall_cnt, stall_cnt_s); end
    n_cmp++; if (in_ready !== 1'b0 || ns_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b/%b want 0", in_ready, ns_in_ready); end
    reset = 1'b1;
    tick(1'b1, '1, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_first_edge_occ: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_first_edge_rdy: got %b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, DW'(i), 1'b1, 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin n_bad++; $display("FAIL stream_%0d: got v=%b d=%h want v=1 d=%0d", i, out_valid, out_data, i); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_rdy_%0d: got %b want 1", i, in_ready); end
    end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || out_data !== DW'(0)) begin n_bad++; $display("FAIL stream_drain: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    int s0;
    a = rand_data(); b = rand_data(); c = rand_data();
    s0 = c16;
    tick(1'b1, a, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd1 || out_data !== a) begin n_bad++; $display("FAIL bp_a: got occ=%0d d=%h want occ=1 d=%h", occupancy, out_data, a); end
    tick(1'b1, b, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full: got occ=%0d rdy=%b want occ=2 rdy=0", occupancy, in_ready); end
    n_cmp++; if (stall_cnt !== 16'(s0 + 1)) begin n_bad++; $display("FAIL bp_stall1: got %0d want %0d", stall_cnt, s0 + 1); end
    tick(1'b1, c, 1'b0, 1'b0);
    n_cmp++; if (occupancy !== 2'd2 || out_data !== a || stall_cnt !== 16'(s0 + 2)) begin n_bad++; $display("FAIL bp_hold: got occ=%0d d=%h st=%0d want occ=2 d=%h st=%0d", occupancy, out_data, stall_cnt, a, s0 + 2); end
    tick(1'b1, c, 1'b1, 1'b0);
    n_cmp++; if (out_data !== b || occupancy !== 2'd1 || stall_cnt !== 16'(s0 + 2)) begin n_bad++; $display("FAIL bp_b: got d=%h occ=%0d st=%0d want d=%h occ=1 st=%0d", out_data, occupancy, stall_cnt, b, s0 + 2); end
    tick(1'b1, c, 1'b1, 1'b0);
    n_cmp++; if (out_data !== c || occupancy !== 2'd1) begin n_bad++; $display("FAIL bp_c: got d=%h occ=%0d want d=%h occ=1", out_data, occupancy, c); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_bad++; $display("FAIL bp_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    int s;
    tick(1'b1, rand_data(), 1'b0, 1'b0);
    tick(1'b1, rand_data(), 1'b0, 1'b0);
    s = c16;
    tick(1'b1, rand_data(), 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_state: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    n_cmp++; if (out_data !== RST_EXP) begin n_bad++; $display("FAIL flush_data: got %h want %h", out_data, RST_EXP); end
    n_cmp++; if (stall_cnt !== 16'(s)) begin n_bad++; $display("FAIL flush_stall: got %0d want %0d", stall_cnt, s); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_rdy: got %b want 1", in_ready); end
    tick(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drop: got v=%b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    tick(1'b1, rand_data(), 1'b0, 1'b0);
    repeat (20) tick(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt_s !== 4'd15 || occupancy_s !== 2'd1) begin n_bad++; $display("FAIL sat_15: got st=%0d occ=%0d want st=15 occ=1", stall_cnt_s, occupancy_s); end
    n_cmp++; if (stall_cnt !== 16'(c16)) begin n_bad++; $display("FAIL sat_wide: got %0d want %0d", stall_cnt, c16); end
    tick(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (stall_cnt_s !== 4'd15 || out_valid_s !== 1'b1) begin n_bad++; $display("FAIL sat_hold: got st=%0d v=%b want st=15 v=1", stall_cnt_s, out_valid_s); end
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] e;
    e = rand_data();
    tick(1'b1, rand_data(), 1'b0, 1'b0);
    tick(1'b1, rand_data(), 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_async: got v=%b occ=%0d rdy=%b want 0/0/0", out_valid, occupancy, in_ready); end
    n_cmp++; if (out_data !== RST_EXP || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_data: got d=%h st=%0d want d=%h st=0", out_data, stall_cnt, RST_EXP); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick(1'b1, e, 1'b1, 1'b0);
    n_cmp++; if (occupancy !== 2'd0) begin n_bad++; $display("FAIL midrst_first: got occ=%0d want 0", occupancy); end
    tick(1'b1, e, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== e) begin n_bad++; $display("FAIL midrst_resume: got v=%b d=%h want v=1 d=%h", out_valid, out_data, e); end
    tick(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_no_skid();
    logic [DW-1:0] a, b;
    a = rand_data(); b = rand_data();
    ns_tick(1'b1, a, 1'b0);
    n_cmp++; if (ns_rdy_seen !== 1'b1 || ns_occupancy !== 2'd1 || ns_out_data !== a) begin n_bad++; $display("FAIL ns_a: got rdy=%b occ=%0d d=%h want 1/1/%h", ns_rdy_seen, ns_occupancy, ns_out_data, a); end
    ns_tick(1'b1, b, 1'b0);
    n_cmp++; if (ns_rdy_seen !== 1'b0 || ns_out_data !== a || ns_occupancy !== 2'd1) begin n_bad++; $display("FAIL ns_hold: got rdy=%b d=%h occ=%0d want 0/%h/1", ns_rdy_seen, ns_out_data, ns_occupancy, a); end
    ns_tick(1'b1, b, 1'b1);
    n_cmp++; if (ns_rdy_seen !== 1'b1 || ns_out_valid !== 1'b1 || ns_out_data !== b) begin n_bad++; $display("FAIL ns_swap: got rdy=%b v=%b d=%h want 1/1/%h", ns_rdy_seen, ns_out_valid, ns_out_data, b); end
    ns_tick(1'b0, '0, 1'b1);
    n_cmp++; if (ns_out_valid !== 1'b0 || ns_occupancy !== 2'd0) begin n_bad++; $display("FAIL ns_empty: got v=%b occ=%0d want 0/0", ns_out_valid, ns_occupancy); end
    for (int i = 0; i < 200; i++) begin
      ns_tick($urandom_range(3) != 0, rand_data(), $urandom_range(1) == 1);
      n_cmp++; if (ns_rdy_seen !== ns_rdy_want) begin n_bad++; $display("FAIL ns_rand_rdy[%0d]: got %b want %b", i, ns_rdy_seen, ns_rdy_want); end
      n_cmp++; if (ns_out_valid !== (nq.size() != 0) || ns_occupancy !== 2'(nq.size())) begin n_bad++; $display("FAIL ns_rand_occ[%0d]: got v=%b occ=%0d want occ=%0d", i, ns_out_valid, ns_occupancy, nq.size()); end
      n_cmp++; if (ns_out_data !== n_data()) begin n_bad++; $display("FAIL ns_rand_data[%0d]: got %h want %h", i, ns_out_data, n_data()); end
      n_cmp++; if (ns_stall_cnt !== 16'(nc16)) begin n_bad++; $display("FAIL ns_rand_stall[%0d]: got %0d want %0d", i, ns_stall_cnt, nc16); end
    end
    ns_tick(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(3) != 0, rand_data(), $urandom_range(2) != 0, $urandom_range(15) == 0);
      n_cmp++; if (in_ready !== m_rdy() || in_ready_s !== m_rdy()) begin n_bad++; $display("FAIL rand_rdy[%0d]: got %b/%b want %b", i, in_ready, in_ready_s, m_rdy()); end
      n_cmp++; if (out_valid !== (mq.size() != 0) || occupancy !== 2'(mq.size())) begin n_bad++; $display("FAIL rand_occ[%0d]: got v=%b occ=%0d want occ=%0d", i, out_valid, occupancy, mq.size()); end
      n_cmp++; if (out_data !== m_data() || out_data_s !== m_data()) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, m_data()); end
      n_cmp++; if (stall_cnt !== 16'(c16) || stall_cnt_s !== 4'(c4)) begin n_bad++; $display("FAIL rand_stall[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt, stall_cnt_s, c16, c4); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_mid_reset();
    test_no_skid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
